cr16_control_fsm: RTL

Multi-cycle controller that drives the ALU's opcode/opext interface and consumes its CLFZN flags. It owns the program counter (PC), the instruction register (IR) and the processor status flags (PSR). It fetches 16-bit instructions and sequences register-file, immediate and memory control. It resolves Bcond/Jcond using the latched flags. It sits between the unified instruction/data memory port and the datapath (register file, ALU, immediate mux).

---
 rtl/cr16_pkg.sv | 96 +++++++++
 rtl/cr16_control_fsm_cond_eval.sv | 41 ++++
 rtl/cr16_control_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 control path: opcodes, opexts, condition codes, PSR bit
// positions, controller states and instruction classification helpers.
package cr16_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_MEM    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP   = 3'd0,
    CL_ALU   = 3'd1,
    CL_BCOND = 3'd2,
    CL_JCOND = 3'd3,
    CL_LOAD  = 3'd4,
    CL_STOR  = 3'd5
  } iclass_e;

  // Primary opcodes, IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LDST  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_MOVIU = 4'b0111;
  localparam logic [3:0] OP_MOVI  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_RSHI  = 4'b1110;

  // Extended opcodes, IR[7:4]
  localparam logic [3:0] EXT_NOP   = 4'b0000;
  localparam logic [3:0] EXT_CMP   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_ADDU  = 4'b0110;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_imm_sext(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI) ||
           (op == OP_MOVI) || (op == OP_BCOND);
  endfunction

  function automatic logic is_imm_zext(input logic [3:0] op);
    return (op == OP_ADDUI) || (op == OP_MOVIU) || (op == OP_RSHI);
  endfunction

  function automatic iclass_e classify(input logic [15:0] ir);
    iclass_e cls;
    cls = CL_NOP;
    case (ir[15:12])
      OP_RTYPE: if (ir[7:4] != EXT_NOP) cls = CL_ALU;
      OP_ADDI, OP_ADDUI, OP_MOVIU, OP_MOVI,
      OP_SUBI, OP_CMPI, OP_RSHI:   cls = CL_ALU;
      OP_BCOND: cls = CL_BCOND;
      OP_LDST: begin
        case (ir[7:4])
          EXT_LOAD:  cls = CL_LOAD;
          EXT_STOR:  cls = CL_STOR;
          EXT_JCOND: cls = CL_JCOND;
          default:   cls = CL_NOP;
        endcase
      end
      default: cls = CL_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cr16_control_fsm_cond_eval.sv
// Branch/jump condition evaluator over the latched PSR; purely combinational.
module cr16_control_fsm_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] psr_i,
  output logic       taken_o
);

  logic c, l, f, z, n;

  assign c = psr_i[FLAG_C];
  assign l = psr_i[FLAG_L];
  assign f = psr_i[FLAG_F];
  assign z = psr_i[FLAG_Z];
  assign n = psr_i[FLAG_N];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_HI: taken_o = l;
      COND_LS: taken_o = !l;
      COND_GT: taken_o = n;
      COND_LE: taken_o = !n;
      COND_FS: taken_o = f;
      COND_FC: taken_o = !f;
      COND_LO: taken_o = !l && !z;
      COND_HS: taken_o = l || z;
      COND_LT: taken_o = !n && !z;
      COND_GE: taken_o = n || z;
      COND_UC: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multi-cycle CR16 controller owning PC/IR/PSR: ALU and branches take 3 cycles, load/store 4.
// Memory accesses hold mem_req until mem_ack with no timeout; each wait cycle stalls the FSM.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IMM_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_b,
  output logic [3:0]  rf_waddr,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_opext,
  output logic        alu_b_sel,
  output logic [15:0] imm,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr_flags
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  psr_q, psr_d;
  logic        mem_go_q, mem_go_d;

  logic [3:0]  opc, ext;
  iclass_e     cls;
  logic [15:0] imm_sext, imm_zext, imm_ext;
  logic        is_cmp, is_arith, cond_taken;

  assign opc = ir_q[15:12];
  assign ext = ir_q[7:4];
  assign cls = classify(ir_q);

  assign imm_sext = {{(16 - IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign imm_zext = {{(16 - IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign imm_ext  = is_imm_sext(opc) ? imm_sext :
                    is_imm_zext(opc) ? imm_zext : 16'h0000;

  assign is_cmp   = ((opc == OP_RTYPE) && (ext == EXT_CMP)) || (opc == OP_CMPI);
  assign is_arith = ((opc == OP_RTYPE) &&
                     ((ext == EXT_ADD) || (ext == EXT_ADDU) || (ext == EXT_SUB))) ||
                    (opc == OP_ADDI) || (opc == OP_ADDUI) || (opc == OP_SUBI);

  // Bcond and Jcond both carry their condition in IR[11:8], so one evaluator serves both.
  cr16_control_fsm_cond_eval u_cond (
    .cond_i  (ir_q[11:8]),
    .psr_i   (psr_q),
    .taken_o (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      psr_q    <= 5'b00000;
      mem_go_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      psr_q    <= psr_d;
      mem_go_q <= mem_go_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    psr_d      = psr_q;
    mem_go_d   = mem_go_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'h0000;
    rf_raddr_a = ir_q[11:8];
    rf_raddr_b = ir_q[3:0];
    rf_waddr   = ir_q[11:8];
    rf_we      = 1'b0;
    rf_wsel    = 1'b0;
    alu_opcode = 4'b0000;
    alu_opext  = 4'b0000;
    alu_b_sel  = 1'b0;
    imm        = 16'h0000;
    psr_flags  = psr_q;

    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        imm      = imm_ext;
        mem_go_d = 1'b0;
        state_d  = ((cls == CL_LOAD) || (cls == CL_STOR)) ? ST_MEM : ST_EXEC;
      end

      ST_EXEC: begin
        imm     = imm_ext;
        state_d = ST_FETCH;
        if (cls != CL_NOP) begin
          alu_opcode = opc;
          alu_opext  = ext;
        end
        case (cls)
          CL_ALU: begin
            alu_b_sel = (opc != OP_RTYPE);
            rf_we     = !is_cmp;
            if (is_arith) begin
              psr_d[FLAG_C] = alu_flags[FLAG_C];
              psr_d[FLAG_F] = alu_flags[FLAG_F];
            end else if (is_cmp) begin
              psr_d[FLAG_L] = alu_flags[FLAG_L];
              psr_d[FLAG_Z] = alu_flags[FLAG_Z];
              psr_d[FLAG_N] = alu_flags[FLAG_N];
            end
          end
          // pc_q already points past the branch, so the displacement is relative to PC+1.
          CL_BCOND: if (cond_taken) pc_d = pc_q + imm_sext;
          CL_JCOND: if (cond_taken) pc_d = rf_rdata_b;
          default: ;
        endcase
      end

      ST_MEM: begin
        // First MEM cycle lets the address register read settle; the request follows.
        mem_addr = rf_rdata_b;
        mem_go_d = 1'b1;
        if (mem_go_q) begin
          mem_req = 1'b1;
          mem_we  = (cls == CL_STOR);
          if (mem_ack) begin
            rf_we   = (cls == CL_LOAD);
            rf_wsel = (cls == CL_LOAD);
            state_d = ST_FETCH;
          end
        end
      end

      default: state_d = ST_FETCH;
    endcase

    // Outputs collapse as soon as reset asserts, even in the middle of an access.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 16'h0000;
      rf_raddr_a = 4'h0;
      rf_raddr_b = 4'h0;
      rf_waddr   = 4'h0;
      rf_we      = 1'b0;
      rf_wsel    = 1'b0;
      alu_opcode = 4'b0000;
      alu_opext  = 4'b0000;
      alu_b_sel  = 1'b0;
      imm        = 16'h0000;
      psr_flags  = 5'b00000;
    end
  end

endmodule
